// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract over one shared 8-bit adder, LS byte first; NWORDS cycles accept->done.
// No backpressure: start is taken only in IDLE/DONE, ignored (not queued) while busy.

module hybrid_adder (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);
   logic [4:0] lo, hi0, hi1;

   // Ripple low nibble; high nibble precomputed for both carry-ins and selected.
   assign lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, ci};
   assign hi0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
   assign hi1 = hi0 + 5'd1;
   assign s   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
   assign co  = lo[4] ? hi1[4] : hi0[4];
endmodule

module multiword_add_seq #(
   parameter int NWORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [8*NWORDS-1:0]   a,
   input  logic [8*NWORDS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NWORDS-1:0]   result,
   output logic                  cout,
   output logic                  overflow
);
   localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [NWORDS-1:0][7:0]   a_q, b_q, acc_q, acc_d;
   logic                     sub_q, carry_q;
   logic [IW-1:0]            idx_q;
   logic [7:0]               a_byte, b_byte, sum_byte;
   logic                     add_co, accept, last;

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));
   assign last   = (idx_q == IW'(NWORDS - 1));
   assign a_byte = a_q[idx_q];
   assign b_byte = b_q[idx_q] ^ {8{sub_q}};

   hybrid_adder u_add (
      .x  (a_byte),
      .y  (b_byte),
      .ci (carry_q),
      .s  (sum_byte),
      .co (add_co)
   );

   always_comb begin
      acc_d        = acc_q;
      acc_d[idx_q] = sum_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         sub_q   <= sub;
         carry_q <= sub;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         acc_q   <= acc_d;
         carry_q <= add_co;
         idx_q   <= idx_q + 1'b1;
         // Outputs only move on the MS byte, so they hold across IDLE and the next RUN.
         if (last) begin
            result   <= acc_d;
            cout     <= add_co;
            overflow <= (a_byte[7] == b_byte[7]) && (sum_byte[7] != a_byte[7]);
         end
      end
   end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq at NWORDS=4, 2 and 8; vectors, handshake corners and randomized model check.
module tb_multiword_add_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_c = 1'b0;
   logic        sub_in = 1'b0;
   logic [63:0] a_in = '0, b_in = '0;
   int          sel = 4;
   int          checks = 0, failures = 0;

   logic        start4, start2, start8;
   logic        busy4, done4, cout4, ovf4;
   logic        busy2, done2, cout2, ovf2;
   logic        busy8, done8, cout8, ovf8;
   logic [31:0] result4;
   logic [15:0] result2;
   logic [63:0] result8;
   logic [63:0] res_m;
   logic        busy_m, done_m, cout_m, ovf_m;

   always #5 clk = ~clk;

   assign start4 = start_c && (sel == 4);
   assign start2 = start_c && (sel == 2);
   assign start8 = start_c && (sel == 8);

   multiword_add_seq #(.NWORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub_in), .a(a_in[31:0]), .b(b_in[31:0]),
      .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(ovf4));
   multiword_add_seq #(.NWORDS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]),
      .busy(busy2), .done(done2), .result(result2), .cout(cout2), .overflow(ovf2));
   multiword_add_seq #(.NWORDS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub_in), .a(a_in), .b(b_in),
      .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8));

   always_comb begin
      res_m = {32'b0, result4}; busy_m = busy4; done_m = done4; cout_m = cout4; ovf_m = ovf4;
      if (sel == 2) begin
         res_m = {48'b0, result2}; busy_m = busy2; done_m = done2; cout_m = cout2; ovf_m = ovf2;
      end else if (sel == 8) begin
         res_m = result8; busy_m = busy8; done_m = done8; cout_m = cout8; ovf_m = ovf8;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // busy and done must never overlap on the selected instance.
   always @(negedge clk) begin
      if (rst_n) chk("busy_done_excl", {63'b0, busy_m && done_m}, 64'd0);
   end

   // Reference: signed/unsigned full-width arithmetic, independent of byte slicing.
   function automatic void ref_op(input logic [63:0] av, input logic [63:0] bv, input logic s,
                                  input int nb, output logic [63:0] r, output logic c, output logic o);
      logic [65:0] one, ua, ub, lim, mask, tmp;
      logic signed [65:0] sa, sb, sr;
      one  = 66'd1;
      mask = (one << nb) - one;
      ua   = {2'b0, av} & mask;
      ub   = {2'b0, bv} & mask;
      lim  = one << (nb - 1);
      sa   = ua[nb-1] ? ua - (one << nb) : ua;
      sb   = ub[nb-1] ? ub - (one << nb) : ub;
      sr   = s ? sa - sb : sa + sb;
      tmp  = sr & mask;
      r    = tmp[63:0];
      o    = (sr >= $signed(lim)) || (sr < -$signed(lim));
      tmp  = (ua + ub) >> nb;
      c    = s ? (ua >= ub) : tmp[0];
   endfunction

   // Issue one op on the selected instance; inj>=0 pulses a bogus start at that RUN cycle.
   task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input logic s, input int inj,
                        output logic [63:0] r, output logic c, output logic o,
                        output int lat, output int bc);
      a_in = av; b_in = bv; sub_in = s; start_c = 1'b1;
      tick();
      start_c = 1'b0;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; sub_in = ~s;
      lat = 0; bc = 0;
      while (!done_m && lat < 40) begin
         if (busy_m) bc++;
         start_c = (lat == inj);
         if (lat == inj) begin a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'h1; end
         tick();
         lat++;
      end
      start_c = 1'b0;
      r = res_m; c = cout_m; o = ovf_m;
   endtask

   typedef struct {
      logic [31:0] a, b;
      logic        s;
      logic [31:0] r;
      logic        c, o;
   } vec_t;

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vecs[7];
      logic [63:0] r, er;
      logic        c, o, ec, eo;
      int          lat, bc, dcnt;

      vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      // Asynchronous reset assertion mid-cycle.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ctl4", {busy4, done4, cout4, ovf4}, 64'd0);
      chk("rst_res4", result4, 64'd0);
      chk("rst_ctl2", {busy2, done2, cout2, ovf2}, 64'd0);
      chk("rst_res8", result8, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_busy_done", {busy4, done4}, 64'd0);

      sel = 4;
      for (int i = 0; i < 7; i++) begin
         do_op({32'b0, vecs[i].a}, {32'b0, vecs[i].b}, vecs[i].s, -1, r, c, o, lat, bc);
         chk($sformatf("vec%0d_result", i), r, {32'b0, vecs[i].r});
         chk($sformatf("vec%0d_cout", i), {63'b0, c}, {63'b0, vecs[i].c});
         chk($sformatf("vec%0d_ovf", i), {63'b0, o}, {63'b0, vecs[i].o});
         chk($sformatf("vec%0d_latency", i), lat, 64'd4);
         chk($sformatf("vec%0d_busycycles", i), bc, 64'd4);
      end

      // start during RUN cycle 2 must be ignored.
      do_op(64'h1111_1111, 64'h2222_2222, 1'b0, 1, r, c, o, lat, bc);
      chk("inj_result", r, 64'h3333_3333);
      chk("inj_latency", lat, 64'd4);
      tick();
      chk("inj_no_rerun", {busy4, done4}, 64'd0);

      // Back-to-back: start held in the DONE cycle.
      do_op(64'h10, 64'h20, 1'b0, -1, r, c, o, lat, bc);
      chk("b2b_first", r, 64'h30);
      a_in = 64'h1; b_in = 64'h1; sub_in = 1'b0; start_c = 1'b1;
      tick();
      start_c = 1'b0;
      chk("b2b_accept_busy", {busy4, done4}, 64'h2);
      lat = 1;
      while (!done4 && lat < 40) begin tick(); lat++; end
      chk("b2b_gap", lat, 64'd5);
      chk("b2b_result", result4, 64'h2);

      // Reset in RUN cycle 2: abandon, clear outputs immediately, no done.
      a_in = 64'h5555_5555; b_in = 64'h1; sub_in = 1'b0; start_c = 1'b1;
      tick();
      start_c = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ctl", {busy4, done4, cout4, ovf4}, 64'd0);
      chk("midrst_res", result4, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (done4 || busy4) dcnt++; end
      chk("midrst_no_done", dcnt, 64'd0);
      do_op(64'h0001_0000, 64'h1, 1'b1, -1, r, c, o, lat, bc);
      chk("midrst_after_res", r, 64'h0000_FFFF);
      chk("midrst_after_cout", {63'b0, c}, 64'd1);
      chk("midrst_after_ovf", {63'b0, o}, 64'd0);

      // NWORDS=2.
      sel = 2;
      do_op(64'hFFFF, 64'h0001, 1'b0, -1, r, c, o, lat, bc);
      chk("n2_result", r, 64'h0);
      chk("n2_cout", {63'b0, c}, 64'd1);
      chk("n2_latency", lat, 64'd2);

      // NWORDS=8 randomized against the reference.
      sel = 8;
      for (int i = 0; i < 1000; i++) begin
         logic [63:0] av, bv;
         av = {$urandom, $urandom};
         bv = {$urandom, $urandom};
         if (i % 50 == 7) bv = av;
         if (i % 50 == 13) av = 64'h8000_0000_0000_0000;
         ref_op(av, bv, i[0], 64, er, ec, eo);
         do_op(av, bv, i[0], -1, r, c, o, lat, bc);
         chk($sformatf("n8_op%0d_result", i), r, er);
         chk($sformatf("n8_op%0d_cout", i), {63'b0, c}, {63'b0, ec});
         chk($sformatf("n8_op%0d_ovf", i), {63'b0, o}, {63'b0, eo});
         if (i == 0) chk("n8_latency", lat, 64'd8);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
